uart_tx_streamer: RTL and testbench

//  Byte-stream feeder for the UART transmit path of MY_UART_TOP.
//  - Buffers bytes from the logic-analyzer core in a FIFO.
//  - Acts as initiator of the tx_start/tx_data/tx_done handshake: issues one byte at a time.
//  - Waits for tx_done before issuing the next byte; a timeout guards against a hung transmitter.

---
 rtl/uart_tx_streamer.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_streamer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_streamer.sv
// uart_tx_streamer: buffers upstream bytes in a FIFO and feeds them one at a
// time to a UART transmitter over a tx_start/tx_data/tx_done handshake, with a
// per-byte timeout and an idle gap after every byte.
// Optional build macro UART_TX_CHKSUM_EN appends a two's-complement checksum
// byte after each byte tagged with s_last.
module uart_tx_streamer #(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_done,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               busy,
    output logic               timeout_err,
    input  logic               err_clr
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC);
    localparam int unsigned GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
`ifdef UART_TX_CHKSUM_EN
    localparam int unsigned FW = 9;
`else
    localparam int unsigned FW = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t               state_q, state_d;
    logic [FW-1:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic                 s_ready_q, s_ready_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [GW-1:0]        gcnt_q, gcnt_d;
    logic                 err_q, err_d;
    logic                 wr, pop, tmo_set, byte_end;
    logic [FW-1:0]        wdata, head;

`ifdef UART_TX_CHKSUM_EN
    logic [7:0]           sum_q, sum_d;
    logic                 cur_last_q, cur_last_d;
    logic                 ck_pend_q, ck_pend_d;
    assign wdata = {s_last, s_data};
`else
    logic                 unused_last;
    assign unused_last = s_last;
    assign wdata       = s_data;
`endif

    assign head        = mem_q[rd_ptr_q];
    assign wr          = s_valid & s_ready_q;
    assign tx_start    = (state_q == S_START);
    assign busy        = (state_q != S_IDLE);
    assign s_ready     = s_ready_q;
    assign tx_data     = tx_data_q;
    assign fifo_level  = level_q;
    assign timeout_err = err_q;

    // Next-state and handshake control: one byte in flight at a time.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tcnt_d    = tcnt_q;
        gcnt_d    = gcnt_q;
        pop       = 1'b0;
        tmo_set   = 1'b0;
        byte_end  = 1'b0;
`ifdef UART_TX_CHKSUM_EN
        sum_d      = sum_q;
        cur_last_d = cur_last_q;
        ck_pend_d  = ck_pend_q;
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef UART_TX_CHKSUM_EN
                // A pending checksum goes out before any further FIFO data.
                if (ck_pend_q) begin
                    tx_data_d  = ~sum_q + 8'd1;
                    sum_d      = '0;
                    ck_pend_d  = 1'b0;
                    cur_last_d = 1'b0;
                    state_d    = S_START;
                end else if (level_q != '0) begin
                    pop        = 1'b1;
                    tx_data_d  = head[7:0];
                    sum_d      = sum_q + head[7:0];
                    cur_last_d = head[8];
                    state_d    = S_START;
                end
`else
                if (level_q != '0) begin
                    pop       = 1'b1;
                    tx_data_d = head;
                    state_d   = S_START;
                end
`endif
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter starts at 0 on the first WAIT cycle, so the abort
                // edge lands TIMEOUT_CYC cycles after the tx_start cycle.
                if (tx_done) begin
                    byte_end = 1'b1;
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 2)) begin
                    tmo_set  = 1'b1;
                    byte_end = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (byte_end) begin
                    gcnt_d  = '0;
                    state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
`ifdef UART_TX_CHKSUM_EN
                    if (cur_last_q) ck_pend_d = 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (32'(gcnt_q) == GAP_CYC - 1) state_d = S_IDLE;
                else                            gcnt_d  = gcnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointer/level bookkeeping and sticky timeout flag.
    always_comb begin
        wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({wr, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        s_ready_d = (level_d != LVL_FULL);
        if (tmo_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wdata;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            s_ready_q <= 1'b0;
            tx_data_q <= '0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
            err_q     <= 1'b0;
`ifdef UART_TX_CHKSUM_EN
            sum_q      <= '0;
            cur_last_q <= 1'b0;
            ck_pend_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            s_ready_q <= s_ready_d;
            tx_data_q <= tx_data_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            err_q     <= err_d;
`ifdef UART_TX_CHKSUM_EN
            sum_q      <= sum_d;
            cur_last_q <= cur_last_d;
            ck_pend_q  <= ck_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Testbench for uart_tx_streamer: scoreboard of expected transmitted bytes,
// cycle-level reference model of handshake timing, FIFO occupancy and error flag.
module tb_uart_tx_streamer;

    localparam int TO  = 1000;
    localparam int GAP = 2;
`ifdef UART_TX_CHKSUM_EN
    localparam int T5_N = 4;
`else
    localparam int T5_N = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic [4:0] fifo_level;
    logic       busy;
    logic       timeout_err;
    logic       err_clr = 1'b0;

    uart_tx_streamer #(.FIFO_AW(4), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .fifo_level(fifo_level),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; bit ck; } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // shared model state (written by the monitor, read by stimulus)
    bit outstanding = 0;
    int start_cyc   = 0;
    int last_done   = -100;
    int n_starts    = 0;
    int max_level   = 0;

    // responder controls
    int resp_lat       = 100;
    int ignore_req     = 0;
    int idle_req       = 0;
    bit pulse_on_start = 0;

    int sum_i       = 0;
    int last_wr_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // UART transmitter model: answers each tx_start after resp_lat cycles.
    initial begin
        int ign_done = 0;
        int idle_done = 0;
        forever begin
            @(negedge clk);
            if (idle_req > idle_done) begin
                idle_done++;
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end else if (tx_start === 1'b1 && rst_n === 1'b1) begin
                if (ignore_req > ign_done) begin
                    ign_done++;
                end else begin
                    if (pulse_on_start) begin
                        tx_done = 1'b1;
                        @(negedge clk);
                        tx_done = 1'b0;
                        repeat (resp_lat - 1) @(negedge clk);
                    end else begin
                        repeat (resp_lat) @(negedge clk);
                    end
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor + reference model, evaluated 1 time unit after each rising edge.
    initial begin
        bit   en = 0;
        bit   sready_m = 0;
        bit   err_model = 0;
        int   level_m = 0;
        logic [7:0] data_m = '0;
        int   c;
        bit   rst_e, done_e, clr_e, wr_e, err_set, ckpend, start_exp, busy_exp;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            c      = cyc;
            rst_e  = rst_n;
            done_e = tx_done;
            clr_e  = err_clr;
            wr_e   = s_valid && sready_m;
            if (!rst_e) begin
                en = 1; outstanding = 0; level_m = 0; err_model = 0;
                sready_m = 0; data_m = '0; last_done = -100;
                exp_q.delete();
                chk("rst_tx_start", tx_start, 0);
                chk("rst_busy", busy, 0);
                chk("rst_level", fifo_level, 0);
                chk("rst_tx_data", tx_data, 0);
                chk("rst_timeout_err", timeout_err, 0);
                chk("rst_s_ready", s_ready, 0);
            end else if (en) begin
                err_set = 0;
                if (outstanding && done_e && (c - 1) > start_cyc) begin
                    outstanding = 0;
                    last_done   = c - 1;
                end else if (outstanding && c == start_cyc + TO) begin
                    outstanding = 0;
                    last_done   = c - 1;
                    err_set     = 1;
                end
                if (err_set)    err_model = 1;
                else if (clr_e) err_model = 0;

                ckpend    = (exp_q.size() > 0) && exp_q[0].ck;
                start_exp = !outstanding && (c >= last_done + GAP + 2) && (level_m > 0 || ckpend);
                chk("tx_start", tx_start, start_exp);
                if (tx_start) begin
                    n_starts++;
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty_at_start", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data_at_start", tx_data, e.d);
                        data_m = e.d;
                        if (!e.ck) level_m--;
                    end
                    outstanding = 1;
                    start_cyc   = c;
                end
                if (wr_e) level_m++;
                sready_m = (level_m != 16);
                busy_exp = outstanding || (c <= last_done + GAP);
                if (fifo_level > max_level) max_level = fifo_level;
                chk("fifo_level", fifo_level, level_m);
                chk("s_ready", s_ready, sready_m);
                chk("busy", busy, busy_exp);
                chk("timeout_err", timeout_err, err_model);
                chk("tx_data_hold", tx_data, data_m);
            end
        end
    end

    task automatic push(input logic [7:0] b, input logic l);
        int k;
        s_valid = 1'b1; s_data = b; s_last = l;
        for (k = 0; k < 3000 && s_ready !== 1'b1; k++) @(negedge clk);
        chk("push_accept", int'(k < 3000), 1);
        last_wr_cyc = cyc;
        exp_q.push_back('{b, 1'b0});
        sum_i += b;
`ifdef UART_TX_CHKSUM_EN
        if (l) begin
            exp_q.push_back('{8'((256 - (sum_i % 256)) % 256), 1'b1});
            sum_i = 0;
        end
`endif
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !outstanding && cyc > last_done + GAP + 2) break;
        end
        chk("wait_idle", int'(k < 5000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k, n0, s0;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // tx_done while idle is ignored
        n0 = n_starts;
        idle_req++;
        repeat (6) @(negedge clk);
        chk("t6_idle_done_busy", busy, 0);
        chk("t6_idle_done_starts", n_starts, n0);

        // single byte latency
        resp_lat = 100;
        push(8'hA5, 1'b0);
        for (k = 0; k < 10 && tx_start !== 1'b1; k++) @(negedge clk);
        chk("t1_latency", cyc, last_wr_cyc + 2);
        chk("t1_data", tx_data, 8'hA5);
        wait_idle();

        // tx_done on the tx_start cycle is ignored
        pulse_on_start = 1; resp_lat = 20;
        push(8'h5A, 1'b0);
        wait_idle();
        pulse_on_start = 0;

        // fill past depth with slow transmitter
        resp_lat = 50; max_level = 0; n0 = n_starts;
        for (int i = 0; i < 20; i++) push(8'(i), 1'b0);
        wait_idle();
        chk("t2_max_level", max_level, 16);
        chk("t2_starts", n_starts - n0, 20);

        // timeout on first byte, second byte still sent
        resp_lat = 10; ignore_req++;
        push(8'hC3, 1'b0);
        push(8'h3C, 1'b0);
        wait_idle();
        chk("t3_err_set", timeout_err, 1);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        chk("t3_err_clr", timeout_err, 0);

        // err_clr on the same edge as a timeout: set wins
        ignore_req++;
        push(8'h77, 1'b0);
        for (k = 0; k < 20 && !outstanding; k++) @(negedge clk);
        s0 = start_cyc;
        for (k = 0; k < 2000 && cyc < s0 + TO - 1; k++) @(negedge clk);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        wait_idle();
        chk("set_wins_err", timeout_err, 1);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;

        // checksum frame
        resp_lat = 8; n0 = n_starts;
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b1);
        wait_idle();
        chk("t5_bytes_sent", n_starts - n0, T5_N);

        // reset mid-WAIT with bytes queued; late tx_done ignored
        resp_lat = 60;
        for (int i = 0; i < 6; i++) push(8'h90 + 8'(i), 1'b0);
        for (k = 0; k < 20 && !outstanding; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        sum_i = 0; n0 = n_starts;
        repeat (80) @(negedge clk);
        chk("t4_busy_after", busy, 0);
        chk("t4_no_starts", n_starts, n0);
        chk("t4_level", fifo_level, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            resp_lat = $urandom_range(1, 30);
            if (i == 20) ignore_req++;
            b = 8'($urandom);
            push(b, ($urandom % 5) == 0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        push(8'hEE, 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
